// File: rtl/id_issue_queue.sv
// ---------------------------------------------------------------------------
// id_issue_queue
//   In-order decode->issue buffer holding DEPTH decoded instructions. Each
//   entry carries an opaque payload and a control-flow flag. With CF_FENCE=1
//   nothing is accepted behind a queued control-flow instruction. A
//   control-flow entry leaving the head in the same cycle releases the fence.
//   DEPTH=1 with CF_FENCE=0 behaves exactly like the legacy single-entry
//   ID/issue register.
//
// Ports
//   clk_i         clock
//   rst_ni        asynchronous reset, active-low; clears entries and storage
//   flush_i       discard all queued entries (highest priority)
//   push_valid_i  decoder offers an entry
//   push_ready_o  entry is accepted this cycle (never depends on push_valid_i)
//   push_data_i   decoded payload
//   push_cf_i     offered entry is a control-flow instruction
//   pop_valid_o   head entry valid
//   pop_data_o    head payload (read straight from storage, no extra latency)
//   pop_cf_o      head control-flow flag
//   pop_ack_i     issue stage consumes the head this cycle
//   count_o       number of valid entries
// ---------------------------------------------------------------------------
module id_issue_queue #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CF_FENCE = 0,
    parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              push_valid_i,
    output logic              push_ready_o,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              push_cf_i,
    output logic              pop_valid_o,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              pop_cf_o,
    input  logic              pop_ack_i,
    output logic [CNT_W-1:0]  count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef logic [PTR_W-1:0] ptr_t;

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  cf_q;
    ptr_t              rd_ptr_q;
    ptr_t              wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  cf_cnt_q;

    logic push;
    logic pop;
    logic space;
    logic fence_ok;

    // Pointers wrap at DEPTH-1 so non-power-of-2 depths work.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_valid_o = (count_q != '0);
    assign pop_data_o  = data_q[rd_ptr_q];
    assign pop_cf_o    = cf_q[rd_ptr_q];
    assign count_o     = count_q;

    assign pop = pop_ack_i & pop_valid_o;

    // A full queue still accepts when its head leaves this cycle.
    assign space = (count_q < CNT_W'(DEPTH)) | pop;

    // With the fence, the only queued cf entry is the tail; once it pops the
    // queue is free of cf entries again.
    assign fence_ok = (CF_FENCE == 0) | (cf_cnt_q == '0) | (pop & pop_cf_o);

    assign push_ready_o = rst_ni & ~flush_i & space & fence_ok;
    assign push         = push_valid_i & push_ready_o;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            cf_cnt_q <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            cf_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q  <= count_q + CNT_W'(push) - CNT_W'(pop);
            cf_cnt_q <= cf_cnt_q + CNT_W'(push & push_cf_i) - CNT_W'(pop & pop_cf_o);
        end
    end

    // NOTE: storage is reset because pop_data_o/pop_cf_o must read as zero
    // after reset; flush leaves it alone since pop_valid_o masks stale data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
            end
            cf_q <= '0;
        end else if (push) begin
            data_q[wr_ptr_q] <= push_data_i;
            cf_q[wr_ptr_q]   <= push_cf_i;
        end
    end

    a_count_le_depth : assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= CNT_W'(DEPTH));

    a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && (count_q == CNT_W'(DEPTH)) && !pop));

    a_cf_le_count : assert property (@(posedge clk_i) disable iff (!rst_ni)
        cf_cnt_q <= count_q);

endmodule
